logic_op_sweeper: RTL and testbench



---
 rtl/logic_op_sweeper.sv | 73 +++++++
 tb/tb_logic_op_sweeper.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_sweeper.sv
// logic_op_sweeper: serialises one A/B operand pair through AND/OR/XOR/XNOR on an external 1-bit logic unit
module logic_op_sweeper #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [1:0]       case_sel,
  output logic             din_one,
  output logic             din_two,
  input  logic             lu_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_and,
  output logic [WIDTH-1:0] res_or,
  output logic [WIDTH-1:0] res_xor,
  output logic [WIDTH-1:0] res_xnor,
  output logic             busy
);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] res [4];
  logic [1:0] op_cnt;
  logic [BW-1:0] bit_cnt;
  logic bit_last, accept;
  assign bit_last = bit_cnt == LAST;
  assign accept = state == IDLE && in_valid;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = RUN;
    else if (state == RUN && op_cnt == 2'd3 && bit_last) state_nxt = DONE;
    else if (state == DONE && out_ready) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      op_cnt <= '0;
      bit_cnt <= '0;
      res <= '{default: '0};
    end else if (accept) begin
      a_reg <= a_in;
      b_reg <= b_in;
      op_cnt <= '0;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      res[op_cnt][bit_cnt] <= lu_dout;
      bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
      if (bit_last) op_cnt <= op_cnt + 1'b1;
    end
  end
  // Logic-unit drive is decoded from registered state only, so lu_dout closes a zero-latency loop
  assign in_ready = state == IDLE;
  assign busy = state == RUN;
  assign out_valid = state == DONE;
  assign case_sel = busy ? op_cnt : 2'b00;
  assign din_one = busy ? a_reg[bit_cnt] : 1'b0;
  assign din_two = busy ? b_reg[bit_cnt] : 1'b0;
  assign res_and = res[0];
  assign res_or = res[1];
  assign res_xor = res[2];
  assign res_xnor = res[3];
endmodule

// File: tb/tb_logic_op_sweeper.sv
// tb_logic_op_sweeper: directed checks of the sweeper against a behavioural logic unit, WIDTH=8 and WIDTH=1
module tb_logic_op_sweeper;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic in_valid = 0, out_ready = 0, in_ready, out_valid, busy;
  logic [7:0] a_in = 0, b_in = 0, res_and, res_or, res_xor, res_xnor;
  logic [1:0] case_sel;
  logic din_one, din_two, lu_dout;

  logic in_valid1 = 0, out_ready1 = 0, in_ready1, out_valid1, busy1;
  logic [0:0] a_in1 = 0, b_in1 = 0, res_and1, res_or1, res_xor1, res_xnor1;
  logic [1:0] case_sel1;
  logic din_one1, din_two1, lu_dout1;

  int vectors = 0, miscompares = 0;

  assign lu_dout = case_sel == 2'd0 ? din_one & din_two : case_sel == 2'd1 ? din_one | din_two :
                   case_sel == 2'd2 ? din_one ^ din_two : ~(din_one ^ din_two);
  assign lu_dout1 = case_sel1 == 2'd0 ? din_one1 & din_two1 : case_sel1 == 2'd1 ? din_one1 | din_two1 :
                    case_sel1 == 2'd2 ? din_one1 ^ din_two1 : ~(din_one1 ^ din_two1);

  logic_op_sweeper #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .case_sel(case_sel), .din_one(din_one), .din_two(din_two), .lu_dout(lu_dout),
    .out_valid(out_valid), .out_ready(out_ready), .res_and(res_and), .res_or(res_or),
    .res_xor(res_xor), .res_xnor(res_xnor), .busy(busy));

  logic_op_sweeper #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a_in(a_in1), .b_in(b_in1),
    .case_sel(case_sel1), .din_one(din_one1), .din_two(din_two1), .lu_dout(lu_dout1),
    .out_valid(out_valid1), .out_ready(out_ready1), .res_and(res_and1), .res_or(res_or1),
    .res_xor(res_xor1), .res_xnor(res_xnor1), .busy(busy1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst = 1;
    step();
    step();
    got = {in_ready, out_valid, busy, case_sel, din_one, din_two, in_ready1, out_valid1, busy1};
    vectors++;
    if (got !== 32'b1_0_0_00_0_0_1_0_0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b want=%b", got[9:0], 10'b1000000100);
    end
    vectors++;
    if ({res_and, res_or, res_xor, res_xnor} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_res got=%h want=00000000", {res_and, res_or, res_xor, res_xnor});
    end
    rst = 0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] a = 8'hA5, b = 8'h3C;
    int ovc = 0;
    in_valid = 1; a_in = a; b_in = b; out_ready = 1;
    step();
    in_valid = 0;
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_accept in_ready=%b busy=%b want 0/1", in_ready, busy);
    end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (case_sel !== 2'(i / 8) || din_one !== a[i % 8] || din_two !== b[i % 8] || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_sel cyc=%0d got sel=%0d d1=%b d2=%b ov=%b want sel=%0d d1=%b d2=%b ov=0",
                 i, case_sel, din_one, din_two, out_valid, i / 8, a[i % 8], b[i % 8]);
      end
      step();
    end
    vectors++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || case_sel !== 2'b00 || din_one !== 1'b0 || din_two !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done ov=%b busy=%b sel=%0d d1=%b d2=%b want 1/0/0/0/0", out_valid, busy, case_sel, din_one, din_two);
    end
    vectors++;
    if ({res_and, res_or, res_xor, res_xnor} !== 32'h24BD9966) begin
      miscompares++;
      $display("FAIL basic_res got=%h want=24bd9966", {res_and, res_or, res_xor, res_xnor});
    end
    while (out_valid && ovc < 10) begin
      ovc++;
      step();
    end
    vectors++;
    if (ovc != 1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_ovlen got=%0d in_ready=%b want=1 in_ready=1", ovc, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int n;
    in_valid = 1; a_in = 8'hA5; b_in = 8'h3C; out_ready = 0;
    step();
    in_valid = 0;
    wait_done(n);
    vectors++;
    if (n != 32) begin
      miscompares++;
      $display("FAIL bp_latency got=%0d want=32", n);
    end
    in_valid = 1; a_in = 8'hFF; b_in = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {res_and, res_or, res_xor, res_xnor} !== 32'h24BD9966) begin
        miscompares++;
        $display("FAIL bp_hold cyc=%0d ov=%b ir=%b res=%h want 1/0/24bd9966", i, out_valid, in_ready,
                 {res_and, res_or, res_xor, res_xnor});
      end
    end
    in_valid = 0; out_ready = 1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res_and !== 8'h24) begin
      miscompares++;
      $display("FAIL bp_release ov=%b ir=%b and=%h want 0/1/24", out_valid, in_ready, res_and);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    in_valid = 1; a_in = 8'h5A; b_in = 8'hC3; out_ready = 1;
    step();
    in_valid = 0;
    for (int i = 0; i < 13; i++) step();
    rst = 1;
    step();
    rst = 0;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || {res_and, res_or, res_xor, res_xnor} !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst ir=%b busy=%b ov=%b res=%h want 1/0/0/00000000", in_ready, busy, out_valid,
               {res_and, res_or, res_xor, res_xnor});
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_quiet ov_cycles=%0d busy=%b want 0/0", seen, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    in_valid = 1; a_in = 8'h00; b_in = 8'hFF; out_ready = 1;
    step();
    a_in = 8'hFF; b_in = 8'hFF;
    wait_done(n);
    vectors++;
    if (n != 32 || {res_and, res_or, res_xor, res_xnor} !== 32'h00FFFF00) begin
      miscompares++;
      $display("FAIL b2b_first n=%0d res=%h want 32/00ffff00", n, {res_and, res_or, res_xor, res_xnor});
    end
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap ir=%b ov=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
    step();
    in_valid = 0;
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept busy=%b ir=%b want 1/0", busy, in_ready);
    end
    wait_done(n);
    vectors++;
    if (n != 32 || {res_and, res_or, res_xor, res_xnor} !== 32'hFFFF00FF) begin
      miscompares++;
      $display("FAIL b2b_second n=%0d res=%h want 32/ffff00ff", n, {res_and, res_or, res_xor, res_xnor});
    end
    step();
  endtask

  task automatic test_width1();
    int ovc = 0;
    in_valid1 = 1; a_in1 = 1'b1; b_in1 = 1'b0; out_ready1 = 1;
    step();
    in_valid1 = 0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (busy1 !== 1'b1 || case_sel1 !== 2'(i) || din_one1 !== 1'b1 || din_two1 !== 1'b0) begin
        miscompares++;
        $display("FAIL w1_sel cyc=%0d busy=%b sel=%0d d1=%b d2=%b want 1/%0d/1/0", i, busy1, case_sel1, din_one1, din_two1, i);
      end
      step();
    end
    vectors++;
    if (out_valid1 !== 1'b1 || {res_and1, res_or1, res_xor1, res_xnor1} !== 4'b0110) begin
      miscompares++;
      $display("FAIL w1_res ov=%b res=%b want 1/0110", out_valid1, {res_and1, res_or1, res_xor1, res_xnor1});
    end
    while (out_valid1 && ovc < 10) begin
      ovc++;
      step();
    end
    vectors++;
    if (ovc != 1 || in_ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL w1_ovlen got=%0d ir=%b want 1/1", ovc, in_ready1);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
